memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_if.sv | 64 ++++++
 rtl/memory_stage.sv | 174 +++++++++++++++++
 tb/tb_memory_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one interface.
// STACK_GUARD_EN adds the stack_fault signal.
interface memory_stage_if #(
    parameter int unsigned ADDR_W = 11
);
    logic [15:0]       result_in;
    logic [15:0]       read_data1_in;
    logic [15:0]       read_data2_in;
    logic [15:0]       ldm_value_in;
    logic [31:0]       pc_plus_one_in;
    logic [2:0]        flags_in;
    logic              mem_read;
    logic              mem_write;
    logic              mem_push;
    logic              mem_pop;
    logic              pc_choose_memory;
    logic              reg_write;
    logic              outport_enable;
    logic [1:0]        memory_address_select;
    logic [1:0]        memory_write_src_select;
    logic [1:0]        wb_sel;
    logic [2:0]        reg_write_address;

    logic              stall;
    logic [15:0]       mem_data_out;
    logic [15:0]       result_out;
    logic [15:0]       ldm_value_out;
    logic              reg_write_out;
    logic              outport_enable_out;
    logic [1:0]        wb_sel_out;
    logic [2:0]        reg_write_address_out;
    logic [31:0]       pc_from_mem_out;
    logic              pc_load;
    logic [ADDR_W-1:0] sp_out;
`ifdef STACK_GUARD_EN
    logic              stack_fault;
`endif

    modport master (
        output result_in, read_data1_in, read_data2_in, ldm_value_in, pc_plus_one_in, flags_in,
        output mem_read, mem_write, mem_push, mem_pop, pc_choose_memory, reg_write,
        output outport_enable, memory_address_select, memory_write_src_select, wb_sel,
        output reg_write_address,
        input  stall, mem_data_out, result_out, ldm_value_out, reg_write_out,
        input  outport_enable_out, wb_sel_out, reg_write_address_out, pc_from_mem_out,
`ifdef STACK_GUARD_EN
        input  stack_fault,
`endif
        input  pc_load, sp_out
    );

    modport slave (
        input  result_in, read_data1_in, read_data2_in, ldm_value_in, pc_plus_one_in, flags_in,
        input  mem_read, mem_write, mem_push, mem_pop, pc_choose_memory, reg_write,
        input  outport_enable, memory_address_select, memory_write_src_select, wb_sel,
        input  reg_write_address,
        output stall, mem_data_out, result_out, ldm_value_out, reg_write_out,
        output outport_enable_out, wb_sel_out, reg_write_address_out, pc_from_mem_out,
`ifdef STACK_GUARD_EN
        output stack_fault,
`endif
        output pc_load, sp_out
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: data memory, stack pointer, two-word CALL/RET sequencing FSM.
// Optional STACK_GUARD_EN macro enables stack over/underflow suppression with stack_fault.
module memory_stage #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic          clk,
    input  logic          reset,
    memory_stage_if.slave bus
);
    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SpOne = 1;

    typedef enum logic [1:0] {StIdle, StPush2, StPop2} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [15:0]       mem [Depth];

    logic              push_eff, pop_eff, call_op, ret_op, fault;
    logic              stall, wr_en, rd_en, bubble;
    logic [ADDR_W-1:0] addr, stack_addr;
    logic [15:0]       wdata, rd_word;

    logic [15:0]       mem_data_q, result_q, ldm_value_q;
    logic              reg_write_q, outport_enable_q, pc_load_q, fault_q;
    logic [1:0]        wb_sel_q;
    logic [2:0]        reg_write_address_q;
    logic [31:0]       pc_q;

    // Simultaneous push and pop: the push wins.
    assign push_eff = bus.mem_push;
    assign pop_eff  = bus.mem_pop & ~bus.mem_push;

`ifdef STACK_GUARD_EN
    logic [ADDR_W:0] need_words, free_words, stored_words;
    assign need_words   = (push_eff && bus.memory_write_src_select == 2'b10) ||
                          (pop_eff && bus.pc_choose_memory) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
    assign free_words   = {1'b0, sp_q} + (ADDR_W+1)'(1);
    assign stored_words = {1'b0, ~sp_q};
    assign fault = (state_q == StIdle) &&
                   ((push_eff && need_words > free_words) || (pop_eff && need_words > stored_words));
`else
    assign fault = 1'b0;
`endif

    assign call_op = push_eff & (bus.memory_write_src_select == 2'b10) & ~fault;
    assign ret_op  = pop_eff & bus.pc_choose_memory & ~fault;

    // Pushes address the current SP; pops address the slot above it.
    assign stack_addr = (state_q == StPush2 || (state_q == StIdle && push_eff)) ? sp_q
                                                                                : sp_q + SpOne;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sp_q    <= '1;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (call_op)     state_d = StPush2;
                else if (ret_op) state_d = StPop2;
            end
            StPush2: state_d = StIdle;
            StPop2:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall  = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        bubble = 1'b0;
        sp_d   = sp_q;

        unique case (bus.memory_address_select)
            2'b00:   addr = bus.result_in[ADDR_W-1:0];
            2'b01:   addr = bus.read_data2_in[ADDR_W-1:0];
            default: addr = stack_addr;
        endcase

        unique case (bus.memory_write_src_select)
            2'b00:   wdata = bus.read_data1_in;
            2'b01:   wdata = bus.read_data2_in;
            2'b10:   wdata = (state_q == StPush2) ? bus.pc_plus_one_in[31:16]
                                                  : bus.pc_plus_one_in[15:0];
            default: wdata = {13'b0, bus.flags_in};
        endcase

        unique case (state_q)
            StIdle: begin
                if (!fault) begin
                    wr_en = bus.mem_write | push_eff;
                    rd_en = bus.mem_read | pop_eff;
                    if (push_eff)     sp_d = sp_q - SpOne;
                    else if (pop_eff) sp_d = sp_q + SpOne;
                end
                stall  = (call_op | ret_op) & ~reset;
                bubble = call_op | ret_op;
            end
            StPush2: begin
                addr  = stack_addr;
                wr_en = 1'b1;
                sp_d  = sp_q - SpOne;
            end
            StPop2: begin
                addr  = stack_addr;
                rd_en = 1'b1;
                sp_d  = sp_q + SpOne;
            end
            default: ;
        endcase
    end

    // Contents survive reset; writes are only blocked while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[addr] <= wdata;
    end

    assign rd_word = mem[addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_data_q          <= '0;
            result_q            <= '0;
            ldm_value_q         <= '0;
            reg_write_q         <= 1'b0;
            outport_enable_q    <= 1'b0;
            wb_sel_q            <= '0;
            reg_write_address_q <= '0;
            pc_load_q           <= 1'b0;
            pc_q                <= '0;
            fault_q             <= 1'b0;
        end else begin
            mem_data_q          <= rd_en ? rd_word : 16'h0000;
            result_q            <= bus.result_in;
            ldm_value_q         <= bus.ldm_value_in;
            reg_write_q         <= bus.reg_write & ~bubble;
            outport_enable_q    <= bus.outport_enable & ~bubble;
            wb_sel_q            <= bus.wb_sel;
            reg_write_address_q <= bus.reg_write_address;
            pc_load_q           <= (state_q == StPop2);
            fault_q             <= fault;
            // High word was read in the IDLE cycle and sits in mem_data_q during POP2.
            if (state_q == StPop2) pc_q <= {mem_data_q, rd_word};
        end
    end

    assign bus.stall                 = stall;
    assign bus.mem_data_out          = mem_data_q;
    assign bus.result_out            = result_q;
    assign bus.ldm_value_out         = ldm_value_q;
    assign bus.reg_write_out         = reg_write_q;
    assign bus.outport_enable_out    = outport_enable_q;
    assign bus.wb_sel_out            = wb_sel_q;
    assign bus.reg_write_address_out = reg_write_address_q;
    assign bus.pc_from_mem_out       = pc_q;
    assign bus.pc_load               = pc_load_q;
    assign bus.sp_out                = sp_q;
`ifdef STACK_GUARD_EN
    assign bus.stack_fault           = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed test of memory_stage: loads/stores, single pushes/pops, CALL/RET, reset abort, SP wrap.
module tb_memory_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    memory_stage_if #(.ADDR_W(11)) bus ();

    memory_stage #(.ADDR_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.result_in = '0;               bus.read_data1_in = '0;
        bus.read_data2_in = '0;           bus.ldm_value_in = '0;
        bus.pc_plus_one_in = '0;          bus.flags_in = '0;
        bus.mem_read = 1'b0;              bus.mem_write = 1'b0;
        bus.mem_push = 1'b0;              bus.mem_pop = 1'b0;
        bus.pc_choose_memory = 1'b0;      bus.reg_write = 1'b0;
        bus.outport_enable = 1'b0;        bus.memory_address_select = '0;
        bus.memory_write_src_select = '0; bus.wb_sel = '0;
        bus.reg_write_address = '0;
    endtask

    // Plain load from an absolute address; data lands one cycle later.
    task automatic load_at(input logic [15:0] a, input logic [15:0] exp, input string tag);
        clear_inputs();
        bus.mem_read  = 1'b1;
        bus.result_in = a;
        step();
        chk(tag, {16'h0, bus.mem_data_out}, {16'h0, exp});
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #12;
        chk("reset_sp", {21'h0, bus.sp_out}, 32'h7FF);
        chk("reset_stall", {31'h0, bus.stall}, 32'h0);
        chk("reset_mem_data", {16'h0, bus.mem_data_out}, 32'h0);
        chk("reset_pc_load", {31'h0, bus.pc_load}, 32'h0);
        reset = 1'b0;

        // STD then LDD at 0x0010
        bus.mem_write = 1'b1;
        bus.result_in = 16'h0010;
        bus.read_data1_in = 16'hBEEF;
        step();
        clear_inputs();
        bus.mem_read = 1'b1;
        bus.result_in = 16'h0010;
        bus.reg_write = 1'b1;
        bus.reg_write_address = 3'd3;
        bus.wb_sel = 2'b01;
        bus.ldm_value_in = 16'hA5A5;
        step();
        chk("ldd_data", {16'h0, bus.mem_data_out}, 32'hBEEF);
        chk("ldd_reg_write", {31'h0, bus.reg_write_out}, 32'h1);
        chk("ldd_rwa", {29'h0, bus.reg_write_address_out}, 32'h3);
        chk("ldd_wb_sel", {30'h0, bus.wb_sel_out}, 32'h1);
        chk("ldd_result", {16'h0, bus.result_out}, 32'h0010);
        chk("ldd_ldm", {16'h0, bus.ldm_value_out}, 32'hA5A5);

        // Flags write (src 11) and read_data2 address/source (sel 01)
        clear_inputs();
        bus.mem_write = 1'b1;
        bus.memory_write_src_select = 2'b11;
        bus.flags_in = 3'b101;
        bus.result_in = 16'h0020;
        step();
        clear_inputs();
        bus.mem_write = 1'b1;
        bus.memory_address_select = 2'b01;
        bus.memory_write_src_select = 2'b01;
        bus.read_data2_in = 16'h0030;
        bus.result_in = 16'h0040;
        step();
        load_at(16'h0020, 16'h0005, "flags_word");
        load_at(16'h0030, 16'h0030, "rd2_addr_src");

        // Single push then pop
        clear_inputs();
        bus.mem_push = 1'b1;
        bus.memory_address_select = 2'b10;
        bus.read_data1_in = 16'h1234;
        #1;
        chk("push_no_stall", {31'h0, bus.stall}, 32'h0);
        step();
        chk("push_sp", {21'h0, bus.sp_out}, 32'h7FE);
        clear_inputs();
        bus.mem_pop = 1'b1;
        bus.memory_address_select = 2'b10;
        #1;
        chk("pop_no_stall", {31'h0, bus.stall}, 32'h0);
        step();
        chk("pop_sp", {21'h0, bus.sp_out}, 32'h7FF);
        chk("pop_data", {16'h0, bus.mem_data_out}, 32'h1234);

        // CALL
        clear_inputs();
        bus.mem_push = 1'b1;
        bus.memory_address_select = 2'b10;
        bus.memory_write_src_select = 2'b10;
        bus.pc_plus_one_in = 32'h0001_0020;
        bus.reg_write = 1'b1;
        bus.outport_enable = 1'b1;
        #1;
        chk("call_stall", {31'h0, bus.stall}, 32'h1);
        step();
        chk("call_bubble_rw", {31'h0, bus.reg_write_out}, 32'h0);
        chk("call_bubble_out", {31'h0, bus.outport_enable_out}, 32'h0);
        chk("call_push2_stall", {31'h0, bus.stall}, 32'h0);
        chk("call_sp_mid", {21'h0, bus.sp_out}, 32'h7FE);
        step();
        chk("call_sp", {21'h0, bus.sp_out}, 32'h7FD);
        load_at(16'h07FF, 16'h0020, "call_lo_word");
        load_at(16'h07FE, 16'h0001, "call_hi_word");

        // RET
        clear_inputs();
        bus.mem_pop = 1'b1;
        bus.pc_choose_memory = 1'b1;
        bus.memory_address_select = 2'b10;
        #1;
        chk("ret_stall", {31'h0, bus.stall}, 32'h1);
        step();
        chk("ret_pop2_stall", {31'h0, bus.stall}, 32'h0);
        chk("ret_sp_mid", {21'h0, bus.sp_out}, 32'h7FE);
        chk("ret_no_early_load", {31'h0, bus.pc_load}, 32'h0);
        step();
        clear_inputs();
        chk("ret_pc_load", {31'h0, bus.pc_load}, 32'h1);
        chk("ret_pc", bus.pc_from_mem_out, 32'h0001_0020);
        chk("ret_sp", {21'h0, bus.sp_out}, 32'h7FF);
        step();
        chk("ret_pc_load_pulse", {31'h0, bus.pc_load}, 32'h0);

        // Reset during PUSH2 of a CALL
        clear_inputs();
        bus.mem_push = 1'b1;
        bus.memory_address_select = 2'b10;
        bus.memory_write_src_select = 2'b10;
        bus.pc_plus_one_in = 32'h0003_0004;
        bus.result_in = 16'h0055;
        step();
        chk("abort_result_pre", {16'h0, bus.result_out}, 32'h0055);
        reset = 1'b1;
        #1;
        chk("abort_stall", {31'h0, bus.stall}, 32'h0);
        chk("abort_sp", {21'h0, bus.sp_out}, 32'h7FF);
        chk("abort_result", {16'h0, bus.result_out}, 32'h0);
        chk("abort_mem_data", {16'h0, bus.mem_data_out}, 32'h0);
        clear_inputs();
        #4;
        reset = 1'b0;
        load_at(16'h07FF, 16'h0004, "abort_word_kept");

        // Push and pop together: push wins
        clear_inputs();
        bus.mem_push = 1'b1;
        bus.mem_pop = 1'b1;
        bus.memory_address_select = 2'b10;
        bus.read_data1_in = 16'h7777;
        step();
        chk("pushpop_sp", {21'h0, bus.sp_out}, 32'h7FE);
        clear_inputs();
        bus.mem_pop = 1'b1;
        bus.memory_address_select = 2'b10;
        step();
        chk("pushpop_data", {16'h0, bus.mem_data_out}, 32'h7777);
        chk("pushpop_sp_back", {21'h0, bus.sp_out}, 32'h7FF);

        // Pop on empty stack
        clear_inputs();
        bus.mem_pop = 1'b1;
        bus.memory_address_select = 2'b10;
        step();
        clear_inputs();
`ifdef STACK_GUARD_EN
        chk("empty_pop_sp", {21'h0, bus.sp_out}, 32'h7FF);
        chk("empty_pop_fault", {31'h0, bus.stack_fault}, 32'h1);
        chk("empty_pop_data", {16'h0, bus.mem_data_out}, 32'h0);
        step();
        chk("empty_pop_fault_pulse", {31'h0, bus.stack_fault}, 32'h0);
`else
        chk("empty_pop_wrap", {21'h0, bus.sp_out}, 32'h000);
        step();
        chk("empty_pop_no_stall", {31'h0, bus.stall}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
